spi_slave_ctrl: RTL
===================

Name: spi_slave_ctrl

Overview:
SPI mode-0 target (slave) port. It lets an external SPI master, such as a debug MCU or a second board, exchange bytes with the 68000 through the FPGA. It is the responder-side counterpart of the existing spi_ctrl master, which drives the ENC28J60, SD card and ADC. The pins are oversampled on mclk, and the block exposes a byte-wide TX holding register and RX register to bus_ctrl, plus an active-low interrupt to intr_ctrl.

Parameters:
SYNC_STAGES, 2, number of flip-flop synchronizer stages on sclk, cs_n and mosi (minimum 2).
IDLE_BYTE, 8'hFF, byte shifted out when the TX holding register is empty at a byte load.

Ports:
clk  in  1  system clock, driven from mclk at top level; sclk must be at most clk/8.
rst  in  1  synchronous, active-high reset.
sclk  in  1  SPI clock from the external master (asynchronous to clk).
cs_n  in  1  SPI chip select, active low (asynchronous).
mosi  in  1  SPI data from the master.
miso  out  1  SPI data to the master.
miso_oe  out  1  miso output enable; high only while the block is selected.
tx_data  in  8  byte to send, from bus_ctrl.
tx_wr  in  1  one-clk strobe that writes tx_data into the TX holding register.
rx_data  out  8  last complete received byte.
rx_rd  in  1  one-clk strobe that acknowledges rx_data and clears rx_valid.
ovr_clr  in  1  one-clk strobe that clears rx_overrun and tx_overwrite.
rx_valid  out  1  rx_data holds an unread byte.
tx_empty  out  1  TX holding register is empty.
rx_overrun  out  1  a received byte was lost (sticky).
tx_overwrite  out  1  tx_wr arrived while the TX holding register was full (sticky).
busy  out  1  cs_n is asserted (synchronized view).
irq_n  out  1  active-low interrupt, equal to ~(rx_valid | rx_overrun).

Behaviour:
- Reset (rst=1 at a clk rising edge):
  - miso=0, miso_oe=0, rx_data=0, rx_valid=0, tx_empty=1, rx_overrun=0, tx_overwrite=0, busy=0, irq_n=1.
  - Bit counter=0; shift registers=0; synchronizers preset to the idle state (cs_n=1, sclk=0).
  - Reset asserted mid-transfer aborts the transfer immediately.
- Synchronization: sclk, cs_n and mosi each pass through SYNC_STAGES flip-flops. Edges are detected on the synchronized sclk and cs_n. Every internal action occurs on the clk edge following edge detection.
- States: IDLE and ACTIVE.
- IDLE to ACTIVE on a synchronized cs_n fall:
  - busy=1, miso_oe=1, bit_cnt=0.
  - The TX shift register loads tx_hold if tx_empty=0 (and tx_empty is then set to 1); otherwise it loads IDLE_BYTE.
  - miso = shift[7] from the same clk edge.
- ACTIVE, synchronized sclk rise: rx_shift = {rx_shift[6:0], mosi_sync}; bit_cnt increments modulo 8.
- Byte completion (rise with bit_cnt 7 to 0):
  - rx_data = the completed byte and rx_valid=1.
  - If rx_valid was already 1 and rx_rd is not asserted in the same cycle, rx_overrun=1 and the old byte is overwritten.
- ACTIVE, synchronized sclk fall:
  - If bit_cnt==0, reload the TX shift register using the same rule as the IDLE-to-ACTIVE load (supports back-to-back bytes under a single cs_n).
  - Otherwise shift left.
  - In both cases miso = shift[7].
- ACTIVE to IDLE on a synchronized cs_n rise, including mid-byte:
  - A partial RX byte is discarded and rx_valid is unchanged.
  - bit_cnt=0, miso_oe=0, miso=0, busy=0.
  - An unsent TX shift byte is lost; tx_hold is untouched.
- tx_wr:
  - Sets tx_hold=tx_data and tx_empty=0.
  - If tx_empty was already 0, tx_overwrite=1.
  - tx_wr in the same cycle as a load: the load uses the pre-write hold contents (or IDLE_BYTE); the new byte stays in the hold register and tx_empty=0.
- rx_rd: clears rx_valid. rx_rd in the same cycle as byte completion leaves rx_valid=1 with the new byte and sets no overrun.
- ovr_clr in the same cycle as a new overrun or overwrite event: the set wins.
- Latency: from a pin edge to its internal action is SYNC_STAGES+1 clk. rx_valid rises SYNC_STAGES+1 clk after the 8th sclk rising pin edge.
- sclk edges while cs_n is high are ignored.

Decomposition:
- Package spi_slave_pkg:
  - IDLE_BYTE default.
  - State encoding (IDLE, ACTIVE).
  - Status bit indices for the bus_ctrl status word: 0 rx_valid, 1 tx_empty, 2 rx_overrun, 3 tx_overwrite, 4 busy.
- One sub-module, sync_edge: a SYNC_STAGES synchronizer with rise/fall pulse outputs, instantiated for sclk and cs_n. mosi uses the synchronizer only.

Test Plan:
1. Reset, then tx_wr 8'hA5; master sends 8'h3C under cs_n at sclk=clk/8 -> master receives 8'hA5; rx_data=8'h3C, rx_valid=1, irq_n=0, tx_empty=1.
2. No tx_wr; master clocks 2 bytes (8'h01, 8'h02) under one cs_n without rx_rd -> master receives 8'hFF, 8'hFF; rx_data=8'h02; rx_overrun=1; ovr_clr then clears it.
3. tx_wr 8'h11, then tx_wr 8'h22 before cs_n -> tx_overwrite=1; master receives 8'h22.
4. cs_n deasserted after 5 sclk edges of 8'hFF -> rx_valid stays 0, busy=0, miso_oe=0; next full byte 8'h5A is received correctly.
5. rx_rd pulsed on the same clk as 8th-bit completion of 8'h77 while rx_valid=1 -> rx_valid=1, rx_data=8'h77, rx_overrun=0.
6. rst pulsed mid-byte -> all outputs return to reset values on the next clk; a subsequent transfer of 8'hC3 completes correctly.

Source files
------------

// File: rtl/spi_slave_pkg.sv
// Shared definitions for the SPI mode-0 target port: default idle byte,
// controller state encoding and bit positions of the bus_ctrl status word.
package spi_slave_pkg;

    localparam logic [7:0] IDLE_BYTE_DEF = 8'hFF;

    typedef enum logic {
        ST_IDLE   = 1'b0,
        ST_ACTIVE = 1'b1
    } spi_state_e;

    localparam int STAT_RX_VALID     = 0;
    localparam int STAT_TX_EMPTY     = 1;
    localparam int STAT_RX_OVERRUN   = 2;
    localparam int STAT_TX_OVERWRITE = 3;
    localparam int STAT_BUSY         = 4;

endpackage

// File: rtl/spi_slave_ctrl_sync_edge.sv
// Multi-stage synchronizer for an asynchronous pin with single-clk rise and
// fall pulses derived from the synchronized level.
module sync_edge #(
    parameter int   STAGES  = 2,
    parameter logic RST_VAL = 1'b0
) (
    input  logic clk,
    input  logic rst,
    input  logic d_i,
    output logic rise_o,
    output logic fall_o
);

    logic [STAGES-1:0] sync_q;
    logic              prev_q;

    // Shift the pin through the synchronizer and remember the previous level.
    always_ff @(posedge clk) begin
        if (rst) begin
            sync_q <= {STAGES{RST_VAL}};
            prev_q <= RST_VAL;
        end else begin
            sync_q <= {sync_q[STAGES-2:0], d_i};
            prev_q <= sync_q[STAGES-1];
        end
    end

    assign rise_o =  sync_q[STAGES-1] & ~prev_q;
    assign fall_o = ~sync_q[STAGES-1] &  prev_q;

endmodule

// File: rtl/spi_slave_ctrl.sv
// SPI mode-0 target port oversampled on clk. Exposes a TX holding register
// and an RX register to the host bus plus sticky error flags and an
// active-low interrupt.
module spi_slave_ctrl
    import spi_slave_pkg::*;
#(
    parameter int         SYNC_STAGES = 2,
    parameter logic [7:0] IDLE_BYTE   = IDLE_BYTE_DEF
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       sclk,
    input  logic       cs_n,
    input  logic       mosi,
    output logic       miso,
    output logic       miso_oe,
    input  logic [7:0] tx_data,
    input  logic       tx_wr,
    output logic [7:0] rx_data,
    input  logic       rx_rd,
    input  logic       ovr_clr,
    output logic       rx_valid,
    output logic       tx_empty,
    output logic       rx_overrun,
    output logic       tx_overwrite,
    output logic       busy,
    output logic       irq_n
);

    logic sclk_rise, sclk_fall, cs_rise, cs_fall;
    logic [SYNC_STAGES-1:0] mosi_sync_q;
    logic mosi_s;

    spi_state_e state_q;
    logic [2:0] bit_cnt_q;
    logic [7:0] rx_shift_q, tx_shift_q, tx_hold_q, rx_data_q;
    logic       tx_empty_q, rx_valid_q, rx_overrun_q, tx_overwrite_q;
    logic       miso_q, miso_oe_q, busy_q;

    logic [7:0] load_byte_d, rx_shift_d, tx_shift_d;

    sync_edge #(.STAGES(SYNC_STAGES), .RST_VAL(1'b0)) u_sclk_sync (
        .clk    (clk),
        .rst    (rst),
        .d_i    (sclk),
        .rise_o (sclk_rise),
        .fall_o (sclk_fall)
    );

    sync_edge #(.STAGES(SYNC_STAGES), .RST_VAL(1'b1)) u_cs_sync (
        .clk    (clk),
        .rst    (rst),
        .d_i    (cs_n),
        .rise_o (cs_rise),
        .fall_o (cs_fall)
    );

    // Level-only synchronizer for mosi, same depth so it stays aligned with sclk.
    always_ff @(posedge clk) begin
        if (rst) begin
            mosi_sync_q <= '0;
        end else begin
            mosi_sync_q <= {mosi_sync_q[SYNC_STAGES-2:0], mosi};
        end
    end

    assign mosi_s = mosi_sync_q[SYNC_STAGES-1];

    // Next byte to present on miso, incoming shift value and outgoing shift value.
    always_comb begin
        load_byte_d = tx_empty_q ? IDLE_BYTE : tx_hold_q;
        rx_shift_d  = {rx_shift_q[6:0], mosi_s};
        tx_shift_d  = {tx_shift_q[6:0], 1'b0};
    end

    // Transfer state machine, host register file and sticky flags.
    // Order matters: clears come first so same-cycle set events win, and the
    // tx_wr update comes last so a new byte survives a simultaneous load.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q        <= ST_IDLE;
            bit_cnt_q      <= '0;
            rx_shift_q     <= '0;
            tx_shift_q     <= '0;
            tx_hold_q      <= '0;
            rx_data_q      <= '0;
            tx_empty_q     <= 1'b1;
            rx_valid_q     <= 1'b0;
            rx_overrun_q   <= 1'b0;
            tx_overwrite_q <= 1'b0;
            miso_q         <= 1'b0;
            miso_oe_q      <= 1'b0;
            busy_q         <= 1'b0;
        end else begin
            if (rx_rd) begin
                rx_valid_q <= 1'b0;
            end
            if (ovr_clr) begin
                rx_overrun_q   <= 1'b0;
                tx_overwrite_q <= 1'b0;
            end
            case (state_q)
                ST_IDLE: begin
                    if (cs_fall) begin
                        state_q    <= ST_ACTIVE;
                        busy_q     <= 1'b1;
                        miso_oe_q  <= 1'b1;
                        bit_cnt_q  <= '0;
                        tx_shift_q <= load_byte_d;
                        miso_q     <= load_byte_d[7];
                        tx_empty_q <= 1'b1;
                    end
                end
                ST_ACTIVE: begin
                    if (cs_rise) begin
                        state_q   <= ST_IDLE;
                        bit_cnt_q <= '0;
                        miso_oe_q <= 1'b0;
                        miso_q    <= 1'b0;
                        busy_q    <= 1'b0;
                    end else if (sclk_rise) begin
                        rx_shift_q <= rx_shift_d;
                        bit_cnt_q  <= bit_cnt_q + 3'd1;
                        if (bit_cnt_q == 3'd7) begin
                            rx_data_q  <= rx_shift_d;
                            rx_valid_q <= 1'b1;
                            if (rx_valid_q && !rx_rd) begin
                                rx_overrun_q <= 1'b1;
                            end
                        end
                    end else if (sclk_fall) begin
                        if (bit_cnt_q == 3'd0) begin
                            tx_shift_q <= load_byte_d;
                            miso_q     <= load_byte_d[7];
                            tx_empty_q <= 1'b1;
                        end else begin
                            tx_shift_q <= tx_shift_d;
                            miso_q     <= tx_shift_d[7];
                        end
                    end
                end
                default: state_q <= ST_IDLE;
            endcase
            if (tx_wr) begin
                tx_hold_q  <= tx_data;
                tx_empty_q <= 1'b0;
                if (!tx_empty_q) begin
                    tx_overwrite_q <= 1'b1;
                end
            end
        end
    end

    assign miso         = miso_q;
    assign miso_oe      = miso_oe_q;
    assign rx_data      = rx_data_q;
    assign rx_valid     = rx_valid_q;
    assign tx_empty     = tx_empty_q;
    assign rx_overrun   = rx_overrun_q;
    assign tx_overwrite = tx_overwrite_q;
    assign busy         = busy_q;
    assign irq_n        = ~(rx_valid_q | rx_overrun_q);

endmodule
